// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one synchronous write
// port, and a per-register busy scoreboard. Decode reserves a destination
// register; writeback clears it. Optional hardwired-zero R0 and
// write-to-read bypass.
module regfile_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    parameter int INIT_IDX = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rr1,
    input  logic [ADDR_W-1:0] rr2,
    input  logic [ADDR_W-1:0] wr,
    input  logic              regW,
    input  logic [DATA_W-1:0] dataW,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [DATA_W-1:0] read1,
    output logic [DATA_W-1:0] read2,
    output logic              busy1,
    output logic              busy2,
    output logic              busy_any
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] rf_q [DEPTH];
    logic [DATA_W-1:0] rf_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    // Writes and reserves that target a hardwired-zero R0 are dropped here,
    // so neither the array nor the scoreboard ever change for address 0.
    logic write_ok_s;
    logic rsv_ok_s;

    // Qualify write and reserve requests against the hardwired-zero register.
    always_comb begin
        write_ok_s = regW;
        rsv_ok_s   = rsv_en;
        if ((ZERO_REG != 0) && (wr == {ADDR_W{1'b0}})) begin
            write_ok_s = 1'b0;
        end else begin
            write_ok_s = regW;
        end
        if ((ZERO_REG != 0) && (rsv_addr == {ADDR_W{1'b0}})) begin
            rsv_ok_s = 1'b0;
        end else begin
            rsv_ok_s = rsv_en;
        end
    end

    // Next-state for array and scoreboard. The reserve is applied after the
    // write so that a same-address collision leaves the register busy: the
    // newly issued producer owns it.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (reset) begin
            busy_d = {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                if (INIT_IDX != 0) begin
                    rf_d[i] = DATA_W'(i);
                end else begin
                    rf_d[i] = {DATA_W{1'b0}};
                end
            end
        end else begin
            if (write_ok_s) begin
                rf_d[wr]   = dataW;
                busy_d[wr] = 1'b0;
            end else begin
                busy_d = busy_d;
            end
            if (rsv_ok_s) begin
                busy_d[rsv_addr] = 1'b1;
            end else begin
                busy_d = busy_d;
            end
        end
    end

    // State registers; reset is folded into the next-state logic above.
    always_ff @(posedge clock) begin
        busy_q <= busy_d;
        for (int i = 0; i < DEPTH; i++) begin
            rf_q[i] <= rf_d[i];
        end
    end

    // Read port 1: zero register, then bypass of this cycle's write, then array.
    always_comb begin
        read1 = rf_q[rr1];
        busy1 = busy_q[rr1];
        if ((ZERO_REG != 0) && (rr1 == {ADDR_W{1'b0}})) begin
            read1 = {DATA_W{1'b0}};
            busy1 = 1'b0;
        end else if ((BYPASS != 0) && regW && (wr == rr1)) begin
            read1 = dataW;
            busy1 = rsv_en && (rsv_addr == rr1);
        end else begin
            read1 = rf_q[rr1];
            busy1 = busy_q[rr1];
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        read2 = rf_q[rr2];
        busy2 = busy_q[rr2];
        if ((ZERO_REG != 0) && (rr2 == {ADDR_W{1'b0}})) begin
            read2 = {DATA_W{1'b0}};
            busy2 = 1'b0;
        end else if ((BYPASS != 0) && regW && (wr == rr2)) begin
            read2 = dataW;
            busy2 = rsv_en && (rsv_addr == rr2);
        end else begin
            read2 = rf_q[rr2];
            busy2 = busy_q[rr2];
        end
    end

    // Any outstanding reservation, from stored bits only.
    always_comb begin
        busy_any = |busy_q;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two instances share all inputs.
// Instance 0: ZERO_REG=0, BYPASS=1. Instance 1: ZERO_REG=1, BYPASS=0.
// Both use INIT_IDX=1. Directed scenarios run first, then random traffic
// checked against an array-based reference model.
module tb_regfile_scoreboard;

    logic        clock;
    logic        reset;
    logic [2:0]  rr1, rr2, wr, rsv_addr;
    logic        regW, rsv_en;
    logic [15:0] dataW;

    logic [1:0][15:0] read1_s, read2_s;
    logic [1:0]       busy1_s, busy2_s, busy_any_s;

    int total;
    int bad;

    // reference model state, per instance
    logic [15:0] mdl_rf   [2][8];
    logic        mdl_busy [2][8];
    int          zero_p   [2];
    int          byp_p    [2];

    regfile_scoreboard #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1), .INIT_IDX(1)) dut_a (
        .clock(clock), .reset(reset), .rr1(rr1), .rr2(rr2), .wr(wr), .regW(regW),
        .dataW(dataW), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .read1(read1_s[0]), .read2(read2_s[0]), .busy1(busy1_s[0]), .busy2(busy2_s[0]),
        .busy_any(busy_any_s[0])
    );

    regfile_scoreboard #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0), .INIT_IDX(1)) dut_b (
        .clock(clock), .reset(reset), .rr1(rr1), .rr2(rr2), .wr(wr), .regW(regW),
        .dataW(dataW), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .read1(read1_s[1]), .read2(read2_s[1]), .busy1(busy1_s[1]), .busy2(busy2_s[1]),
        .busy_any(busy_any_s[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_read(input int k, input logic [2:0] a);
        if (zero_p[k] != 0 && a == 3'd0) return 16'h0000;
        if (byp_p[k] != 0 && regW && wr == a) return dataW;
        return mdl_rf[k][a];
    endfunction

    function automatic logic exp_busy(input int k, input logic [2:0] a);
        if (zero_p[k] != 0 && a == 3'd0) return 1'b0;
        if (byp_p[k] != 0 && regW && wr == a) return rsv_en && (rsv_addr == a);
        return mdl_busy[k][a];
    endfunction

    function automatic logic exp_any(input int k);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 8; i++) r = r | mdl_busy[k][i];
        return r;
    endfunction

    // compare every output of both instances against the model
    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("read1[%0d] rr1=%0d", k, rr1), 32'(read1_s[k]), 32'(exp_read(k, rr1)));
            chk($sformatf("read2[%0d] rr2=%0d", k, rr2), 32'(read2_s[k]), 32'(exp_read(k, rr2)));
            chk($sformatf("busy1[%0d] rr1=%0d", k, rr1), 32'(busy1_s[k]), 32'(exp_busy(k, rr1)));
            chk($sformatf("busy2[%0d] rr2=%0d", k, rr2), 32'(busy2_s[k]), 32'(exp_busy(k, rr2)));
            chk($sformatf("busy_any[%0d]", k), 32'(busy_any_s[k]), 32'(exp_any(k)));
        end
    endtask

    // set inputs, let them settle (away from the clock edge), compare
    task automatic apply(input logic rst, input logic [2:0] a1, input logic [2:0] a2,
                         input logic we, input logic [2:0] wa, input logic [15:0] wd,
                         input logic re, input logic [2:0] ra);
        reset = rst; rr1 = a1; rr2 = a2; regW = we; wr = wa; dataW = wd;
        rsv_en = re; rsv_addr = ra;
        #2;
        check_all();
    endtask

    // one clock edge: update model by the register-file rules, return at negedge
    task automatic tick();
        @(posedge clock);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int i = 0; i < 8; i++) begin
                    mdl_rf[k][i]   = 16'(i);
                    mdl_busy[k][i] = 1'b0;
                end
            end else begin
                if (regW && !(zero_p[k] != 0 && wr == 3'd0)) begin
                    mdl_rf[k][wr]   = dataW;
                    mdl_busy[k][wr] = 1'b0;
                end
                if (rsv_en && !(zero_p[k] != 0 && rsv_addr == 3'd0)) begin
                    mdl_busy[k][rsv_addr] = 1'b1;
                end
            end
        end
        @(negedge clock);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        zero_p[0] = 0; byp_p[0] = 1;
        zero_p[1] = 1; byp_p[1] = 0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++) begin
                mdl_rf[k][i]   = 16'h0000;
                mdl_busy[k][i] = 1'b0;
            end
        reset = 1'b1; rr1 = 3'd0; rr2 = 3'd0; regW = 1'b0; wr = 3'd0;
        dataW = 16'h0000; rsv_en = 1'b0; rsv_addr = 3'd0;
        @(negedge clock);
        // reset edge (outputs before it are unknown, so no compare yet)
        tick();

        // 1. reset contents
        apply(1'b0, 3'd5, 3'd7, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
        chk("rst read1", 32'(read1_s[0]), 32'h0005);
        chk("rst read2", 32'(read2_s[0]), 32'h0007);
        chk("rst busy_any", 32'(busy_any_s[0]), 32'h0);

        // 2/3. write with same-cycle read (bypass vs. old value)
        apply(1'b0, 3'd0, 3'd3, 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0);
        chk("bypass read2", 32'(read2_s[0]), 32'hBEEF);
        chk("nobypass read2", 32'(read2_s[1]), 32'h0003);
        tick();
        apply(1'b0, 3'd3, 3'd1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
        chk("wr read1 a", 32'(read1_s[0]), 32'hBEEF);
        chk("wr read1 b", 32'(read1_s[1]), 32'hBEEF);

        // 4. reserve then writeback clears
        apply(1'b0, 3'd4, 3'd1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd4);
        tick();
        apply(1'b0, 3'd4, 3'd1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
        chk("rsv busy1", 32'(busy1_s[0]), 32'h1);
        chk("rsv busy_any", 32'(busy_any_s[0]), 32'h1);
        apply(1'b0, 3'd4, 3'd1, 1'b1, 3'd4, 16'h4444, 1'b0, 3'd0);
        chk("wb bypass busy1", 32'(busy1_s[0]), 32'h0);
        chk("wb nobypass busy1", 32'(busy1_s[1]), 32'h1);
        tick();
        apply(1'b0, 3'd4, 3'd1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
        chk("wb busy_any", 32'(busy_any_s[0]), 32'h0);

        // 5. same-address write + reserve collision
        apply(1'b0, 3'd1, 3'd1, 1'b1, 3'd2, 16'h1234, 1'b1, 3'd2);
        tick();
        apply(1'b0, 3'd2, 3'd1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
        chk("coll read1", 32'(read1_s[0]), 32'h1234);
        chk("coll busy1", 32'(busy1_s[0]), 32'h1);

        // 6. zero register, then reset discards reservations
        apply(1'b0, 3'd1, 3'd1, 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0);
        tick();
        apply(1'b0, 3'd0, 3'd1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
        chk("r0 read1", 32'(read1_s[1]), 32'h0000);
        chk("r0 busy1", 32'(busy1_s[1]), 32'h0);
        chk("r0 plain read1", 32'(read1_s[0]), 32'hFFFF);
        apply(1'b0, 3'd6, 3'd1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6);
        tick();
        apply(1'b1, 3'd6, 3'd1, 1'b1, 3'd5, 16'hAAAA, 1'b1, 3'd3);
        tick();
        apply(1'b0, 3'd6, 3'd5, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
        chk("rst busy_any b", 32'(busy_any_s[1]), 32'h0);
        chk("rst rf6", 32'(read1_s[1]), 32'h0006);
        chk("rst rf5", 32'(read2_s[1]), 32'h0005);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            apply(($urandom_range(0, 29) == 0),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
